// File: rtl/regbank16_wr_pkg.sv
// regbank_pkg: shared types and sizes for the register bank write side.
//   rb_state_t : write-side controller states (IDLE, DRAIN, CLEAR)
//   NREGS      : number of entries in the bank
//   SEL_W      : width of an entry index
package regbank_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} rb_state_t;

    localparam int NREGS = 16;
    localparam int SEL_W = 4;

endpackage

// File: rtl/regbank16_wr_decoder.sv
// One-hot decoders used to generate the per-entry write enables.
//   decoder3_8  : sel[2:0], en -> out[7:0]
//   decoder4_16 : sel[3:0], en -> out[15:0], built from two decoder3_8
//                 halves selected by sel[3] (mirror of the read mux tree).
// Both are purely combinational; out is all zero when en is low.
module decoder3_8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] out
);

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign out[gi] = en && (sel == 3'(gi));
    end

endmodule

module decoder4_16 (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] out
);

    decoder3_8 u_lo (
        .sel (sel[2:0]),
        .en  (en && !sel[3]),
        .out (out[7:0])
    );

    decoder3_8 u_hi (
        .sel (sel[2:0]),
        .en  (en && sel[3]),
        .out (out[15:8])
    );

endmodule

// File: rtl/regbank16_wr.sv
// regbank16_wr: write side of the 16-entry register bank.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   wr_valid : write request present
//   wr_ready : bank can accept a write this cycle
//   wr_sel   : target entry index
//   wr_data  : write data
//   clr_req  : start clear-all sequence (sampled only in IDLE)
//   busy     : clear-all sequence in progress
//   word_en  : registered one-hot of the entry updated on the last edge
//   q        : all entries flattened, entry i at q[i*WIDTH +: WIDTH]
// Accepted writes sit in a one-deep pending register and commit on the
// following edge. A single decoder serves both the commit address and the
// clear counter.
import regbank_pkg::*;

module regbank16_wr #(
    parameter int WIDTH     = 64,
    parameter bit ZERO_LAST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [SEL_W-1:0]       wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [NREGS-1:0]       word_en,
    output logic [NREGS*WIDTH-1:0] q
);

    rb_state_t          state_reg, state_next;
    logic [SEL_W-1:0]   cnt_reg, cnt_next;
    logic               pend_v_reg;
    logic [SEL_W-1:0]   pend_sel_reg;
    logic [WIDTH-1:0]   pend_data_reg;
    logic [NREGS-1:0]   word_en_reg;
    logic               busy_reg;

    logic               accept;
    logic               in_clear;
    logic               pend_dropped;
    logic [SEL_W-1:0]   dec_sel;
    logic               dec_en;
    logic [NREGS-1:0]   dec_out;
    logic [WIDTH-1:0]   bank_wdata;

    assign wr_ready = reset && (state_reg == IDLE);
    assign accept   = wr_valid && wr_ready;
    assign in_clear = (state_reg == CLEAR);

    // A commit to the hardwired-zero entry is consumed but produces no enable.
    assign pend_dropped = ZERO_LAST && (pend_sel_reg == SEL_W'(NREGS - 1));

    // The clear counter borrows the commit decoder; no write can be pending
    // while clearing because wr_ready is low outside IDLE.
    assign dec_sel    = in_clear ? cnt_reg : pend_sel_reg;
    assign dec_en     = in_clear || (pend_v_reg && !pend_dropped);
    assign bank_wdata = in_clear ? '0 : pend_data_reg;

    decoder4_16 u_dec (
        .sel (dec_sel),
        .en  (dec_en),
        .out (dec_out)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    if (pend_v_reg || accept) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = CLEAR;
                        cnt_next   = '0;
                    end
                end
            end
            DRAIN: begin
                // The pending write commits on this edge.
                state_next = CLEAR;
                cnt_next   = '0;
            end
            CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == SEL_W'(NREGS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pend_v_reg    <= 1'b0;
            pend_sel_reg  <= '0;
            pend_data_reg <= '0;
            word_en_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pend_v_reg  <= accept;
            if (accept) begin
                pend_sel_reg  <= wr_sel;
                pend_data_reg <= wr_data;
            end
            word_en_reg <= dec_out;
            busy_reg    <= (state_next != IDLE);
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
        if (ZERO_LAST && (gi == NREGS - 1)) begin : g_zero
            assign q[gi*WIDTH +: WIDTH] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (dec_out[gi]) begin
                    entry_reg <= bank_wdata;
                end
            end
            assign q[gi*WIDTH +: WIDTH] = entry_reg;
        end
    end

    assign word_en = word_en_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_regbank16_wr.sv
// Directed bench for regbank16_wr: single writes, back-to-back writes,
// hardwired zero entry, clear with drain, ignored clear, reset mid-clear.
module tb_regbank16_wr;

    localparam int W = 64;
    localparam int N = 16;

    logic           clk;
    logic           reset;
    logic           wr_valid;
    logic [3:0]     wr_sel;
    logic [W-1:0]   wr_data;
    logic           clr_req;

    logic           wr_ready,  wr_ready0;
    logic           busy,      busy0;
    logic [N-1:0]   word_en,   word_en0;
    logic [N*W-1:0] q,         q0;

    int tests_run = 0;
    int failed    = 0;

    logic [N*W-1:0] exp_q;
    int             busy_cnt;

    regbank16_wr #(.WIDTH(W), .ZERO_LAST(1'b1)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .clr_req(clr_req),
        .busy(busy), .word_en(word_en), .q(q)
    );

    regbank16_wr #(.WIDTH(W), .ZERO_LAST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_sel(wr_sel), .wr_data(wr_data), .clr_req(clr_req),
        .busy(busy0), .word_en(word_en0), .q(q0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N*W-1:0] obs,
                         input logic [N*W-1:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_sel   = '0;
        wr_data  = '0;
        clr_req  = 1'b0;
        exp_q    = '0;

        // Reset state
        step();
        step();
        check("rst_q",        q,        '0);
        check("rst_busy",     busy,     '0);
        check("rst_word_en",  word_en,  '0);
        check("rst_wr_ready", wr_ready, '0);
        reset = 1'b1;
        #1;
        check("post_rst_wr_ready", wr_ready, 1);

        // Single writes to entries 0..14
        for (int i = 0; i < 15; i++) begin
            wr_valid = 1'b1;
            wr_sel   = 4'(i);
            wr_data  = W'(i + 'h100);
            step();                       // accept edge
            wr_valid = 1'b0;
            step();                       // commit edge
            exp_q[i*W +: W] = W'(i + 'h100);
            $display("[TB] write sel=%0d data=%0h word_en=%04h", i, W'(i + 'h100), word_en);
            check("single_word_en", word_en, N'(1) << i);
            check("single_q",       q,       exp_q);
            step();
            check("single_word_en_clr", word_en, '0);
        end

        // Back-to-back writes to 3,4,5
        wr_valid = 1'b1;
        wr_sel = 4'd3; wr_data = 64'hA;
        check("b2b_ready0", wr_ready, 1);
        step();
        wr_sel = 4'd4; wr_data = 64'hB;
        check("b2b_ready1", wr_ready, 1);
        step();
        exp_q[3*W +: W] = 64'hA;
        check("b2b_q3", q, exp_q);
        check("b2b_en3", word_en, 16'h0008);
        wr_sel = 4'd5; wr_data = 64'hC;
        check("b2b_ready2", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        exp_q[4*W +: W] = 64'hB;
        check("b2b_q4", q, exp_q);
        check("b2b_en4", word_en, 16'h0010);
        step();
        exp_q[5*W +: W] = 64'hC;
        check("b2b_q5", q, exp_q);
        check("b2b_en5", word_en, 16'h0020);
        $display("[TB] back-to-back writes sel=3,4,5 done");

        // Zero entry: write all ones to 15
        wr_valid = 1'b1; wr_sel = 4'd15; wr_data = '1;
        step();
        wr_valid = 1'b0;
        step();
        $display("[TB] write sel=15 data=all ones");
        check("zero_q15",       q[15*W +: W],  '0);
        check("zero_word_en",   word_en,       '0);
        check("nozero_q15",     q0[15*W +: W], {W{1'b1}});
        check("nozero_word_en", word_en0,      16'h8000);
        check("zero_q_rest",    q,             exp_q);

        // Clear with drain: write to 7 and clear request on the same edge
        wr_valid = 1'b1; wr_sel = 4'd7; wr_data = 64'h55; clr_req = 1'b1;
        step();
        wr_valid = 1'b0; clr_req = 1'b0;
        busy_cnt = 0;
        if (busy) busy_cnt++;
        check("drain_busy",     busy,     1);
        check("drain_wr_ready", wr_ready, 0);
        check("drain_word_en",  word_en,  '0);
        step();
        if (busy) busy_cnt++;
        check("drain_commit_en", word_en,        16'h0080);
        check("drain_commit_q7", q[7*W +: W],    64'h55);
        for (int k = 0; k < 16; k++) begin
            step();
            if (busy) busy_cnt++;
            check("clear_word_en", word_en, N'(1) << k);
        end
        $display("[TB] clear with drain busy_cnt=%0d", busy_cnt);
        check("clear_busy_cycles", busy_cnt, 17);
        check("clear_done_busy",   busy,     0);
        check("clear_done_ready",  wr_ready, 1);
        check("clear_q",           q,        '0);
        check("clear_q_nozero",    q0,       '0);

        // Clear with clr_req and wr_valid held during CLEAR
        clr_req = 1'b1;
        step();
        wr_valid = 1'b1; wr_sel = 4'd9; wr_data = 64'h77;
        check("ign_busy",  busy,     1);
        check("ign_ready", wr_ready, 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) check("ign_ready_low", wr_ready, 0);
            else        check("ign_idle",      busy,     0);
        end
        wr_valid = 1'b0; clr_req = 1'b0;
        step();
        step();
        $display("[TB] ignored clear / blocked writes done");
        check("ign_no_restart", busy, 0);
        check("ign_q",          q,    '0);

        // Reset mid-clear
        exp_q = '0;
        wr_valid = 1'b1; wr_sel = 4'd10; wr_data = 64'hAA;
        step();
        wr_valid = 1'b0;
        step();
        exp_q[10*W +: W] = 64'hAA;
        check("pre_rst_q10", q, exp_q);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("mid_clear_q10", q[10*W +: W], 64'hAA);
        reset = 1'b0;
        #1;
        check("midrst_q",        q,        '0);
        check("midrst_busy",     busy,     0);
        check("midrst_word_en",  word_en,  '0);
        check("midrst_wr_ready", wr_ready, 0);
        step();
        reset = 1'b1;
        #1;
        check("rerel_wr_ready", wr_ready, 1);
        wr_valid = 1'b1; wr_sel = 4'd2; wr_data = 64'h9;
        step();
        wr_valid = 1'b0;
        step();
        exp_q = '0;
        exp_q[2*W +: W] = 64'h9;
        $display("[TB] write after reset sel=2 data=9 word_en=%04h", word_en);
        check("after_rst_en", word_en, 16'h0004);
        check("after_rst_q",  q,       exp_q);
        check("after_rst_busy", busy,  0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        failed++;
        $display("FAIL timeout: observed no finish, required finish before 100000");
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/regbank16_wr.md
# regbank16_wr

Write side of the 16-entry register bank. Accepts write requests through a valid/ready handshake and registers each request for one cycle. On the following edge it decodes the 4-bit select to a one-hot enable and updates the addressed entry. A 16-cycle clear-all sequence zeroes the bank. All 16 entries are exposed as a flattened bus, so the read side (one 16:1 mux per bit, per read port) selects from it directly.

## Interface
- `WIDTH`, default 64: bits per entry.
- `ZERO_LAST`, default 1: when 1, entry 15 is hardwired to zero and writes to it are discarded.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low (asserted at 0).
- `wr_valid`, in, 1: write request present.
- `wr_ready`, out, 1: bank can accept a write this cycle.
- `wr_sel`, in, 4: target entry index.
- `wr_data`, in, WIDTH: write data.
- `clr_req`, in, 1: start the clear-all sequence. Sampled only in IDLE.
- `busy`, out, 1: a clear-all sequence is in progress (state is not IDLE).
- `word_en`, out, 16: registered one-hot of the entry updated on the last edge; all zero if no entry was updated.
- `q`, out, 16*WIDTH: entry i is `q[i*WIDTH +: WIDTH]`.

## Operation
- Handshake: a write is accepted on an edge where `wr_valid && wr_ready`. On that edge `wr_sel` and `wr_data` are captured into a pending register and `pend_v` is set.
- Commit: on the next edge the pending write is decoded and the entry is updated. `word_en` shows the one-hot for one cycle.
- Back-to-back accepts are allowed, giving a throughput of 1 write per cycle.
- `wr_ready` = `reset` high AND state == IDLE. It does not depend on `wr_valid` or `clr_req`.
- With `ZERO_LAST`=1, a write to 15 is accepted and consumed, but `q` entry 15 stays 0 and `word_en` stays 0.
- FSM states are IDLE, DRAIN and CLEAR.
  - IDLE with `clr_req`=1 and a pending write (existing, or accepted on this same edge) -> DRAIN.
  - IDLE with `clr_req`=1 and no pending write -> CLEAR, with the counter set to 0.
  - DRAIN: the pending write commits -> CLEAR, with the counter set to 0.
  - CLEAR: entry `cnt` is zeroed, `word_en` = one-hot(`cnt`), `cnt` increments. At `cnt`==15 the FSM returns to IDLE.
- `clr_req` is ignored in DRAIN and CLEAR. Requests are not queued.
- Simultaneous `wr_valid` and `clr_req` in IDLE: the write is accepted, drained, and then cleared. The final value of that entry is 0.
- Reset asserted at any time:
  - all entries become 0; `pend_v`, `word_en` and `cnt` become 0; state becomes IDLE; `busy` is 0; `wr_ready` is 0.
  - a pending write is dropped and an in-progress clear is aborted.

## Timing
- Write latency: accept on edge N, `q` updated after edge N+1. `word_en` is valid in cycle N+1..N+2.
- No read-after-write bypass inside this block. Forwarding is the consumer's responsibility.
- Clear sequence length: 16 cycles from IDLE, or 17 with a drain. `wr_ready` is low for exactly that many cycles.
- `wr_ready` goes high in the first cycle after reset deasserts.
- All outputs except `wr_ready` come directly from flops.

## Structure
- `regbank_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} rb_state_t`
  - `localparam NREGS = 16`
  - `localparam SEL_W = 4`
- Sub-module `decoder4_16` (`sel`[3:0], `en`, `out`[15:0]) is a purely combinational one-hot decoder. It is built from two `decoder3_8` instances gated by `sel[3]`, the inverse of the read-side mux tree. One instance decodes the commit address; the clear counter reuses it through a select mux.
- The bank is 16 x WIDTH flops, one enable per entry.

## Test plan
- Reset then single writes: write sel=i, data=i+0x100 for i=0..14 -> each `q` entry matches 2 cycles after accept. `word_en`=1<<i for one cycle.
- Back-to-back: `wr_valid` held for 3 cycles, sel=3,4,5, data=A,B,C -> `wr_ready` stays 1. Entries 3,4,5 = A,B,C on consecutive cycles.
- Zero entry: write sel=15, data=all ones -> entry 15 stays 0, `word_en`=0. Repeat with `ZERO_LAST`=0 -> entry 15 = all ones.
- Clear with drain: fill all entries, then in the same cycle assert `wr_valid` (sel=7, data=0x55) and `clr_req` -> `busy` is high for 17 cycles. `word_en` steps 1<<0..1<<15. All entries end at 0.
- Ignored clear and blocked writes: assert `clr_req` and `wr_valid` during CLEAR -> `wr_ready`=0 and no extra sequence starts. The bank is back in IDLE after 16 cycles.
- Reset mid-clear: assert `reset`=0 at `cnt`=6 -> all entries 0, `busy`=0, `word_en`=0 immediately. After release, a write of 0x9 to sel=2 commits normally.
